// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state encoding, matrix geometry and key-code helpers for the keypad scanner
package keypad_pkg;
  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  typedef enum logic [1:0] {IDLE, DOWN, WAIT_RELEASE} state_e;
  function automatic logic [3:0] key_code_of(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction
  function automatic logic [3:0] onehot_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) if (v[i]) idx = 4'(i);
    return idx;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: accepts a key bitmap once it has been identical for DEBOUNCE_SCANS full scans
module key_debounce #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_done_i,
  input  logic [15:0] bitmap_i,
  output logic [15:0] stable_o,
  output logic        stable_event_o
);
  localparam logic [3:0] N = 4'(DEBOUNCE_SCANS);
  logic [15:0] prev_q, prev_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        same;
  assign same = bitmap_i == prev_q;
  always_comb begin
    prev_d = scan_done_i ? bitmap_i : prev_q;
    cnt_d  = !scan_done_i ? cnt_q : !same ? 4'd1 : cnt_q == N ? cnt_q : cnt_q + 4'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end
  // Fires only on the scan that brings the count up to N, never while saturated.
  assign stable_event_o = scan_done_i && same && cnt_q == N - 4'd1;
  assign stable_o = prev_q;
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 hex keypad scanner with debounce, single-key acceptance and a 16-bit entry register
module keypad_scan import keypad_pkg::*; #(
  parameter int SCAN_BITS      = 17,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  col_n,
  input  logic [3:0]  row_n,
  input  logic        clear,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_down,
  output logic [15:0] data
);
  logic [3:0]           row_s1_q, row_s2_q;
  logic [SCAN_BITS-1:0] dwell_q;
  logic [1:0]           col_q;
  logic [15:0]          bm_q, bm_d;
  logic                 dwell_end, scan_done;
  logic [15:0]          stable;
  logic                 stable_event;
  logic [4:0]           pc;
  state_e               state_q, state_d;
  logic                 key_valid_q, key_valid_d, down_q, down_d, emit;
  logic [3:0]           code_q, code_d;
  logic [15:0]          data_q, data_d, data_cl;
  assign dwell_end = &dwell_q;
  assign scan_done = dwell_end && col_q == 2'(NUM_COLS - 1);
  assign col_n = ~(4'b0001 << col_q);
  // The current column's rows overwrite their slice on its last dwell cycle.
  always_comb begin
    bm_d = bm_q;
    for (int r = 0; r < NUM_ROWS; r++)
      if (dwell_end) bm_d[key_code_of(2'(r), col_q)] = ~row_s2_q[r];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      row_s1_q <= '1;
      row_s2_q <= '1;
      dwell_q  <= '0;
      col_q    <= '0;
      bm_q     <= '0;
    end else begin
      row_s1_q <= row_n;
      row_s2_q <= row_s1_q;
      dwell_q  <= dwell_q + SCAN_BITS'(1);
      col_q    <= dwell_end ? col_q + 2'd1 : col_q;
      bm_q     <= bm_d;
    end
  end
  key_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
    .clk            (clk),
    .reset          (reset),
    .scan_done_i    (scan_done),
    .bitmap_i       (bm_d),
    .stable_o       (stable),
    .stable_event_o (stable_event)
  );
  assign pc = popcount16(stable);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      key_valid_q <= 1'b0;
      code_q      <= '0;
      down_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      key_valid_q <= key_valid_d;
      code_q      <= code_d;
      down_q      <= down_d;
      data_q      <= data_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (stable_event)
      case (state_q)
        IDLE:         state_d = pc == 5'd1 ? DOWN : pc > 5'd1 ? WAIT_RELEASE : IDLE;
        DOWN:         state_d = pc == 5'd0 ? IDLE : stable != (16'b1 << code_q) ? WAIT_RELEASE : DOWN;
        WAIT_RELEASE: state_d = pc == 5'd0 ? IDLE : WAIT_RELEASE;
        default:      state_d = IDLE;
      endcase
  end
  // Clear is applied before the shift so a coincident emission survives it.
  always_comb begin
    emit        = stable_event && state_q == IDLE && pc == 5'd1;
    key_valid_d = emit;
    code_d      = emit ? onehot_index(stable) : code_q;
    down_d      = state_d == DOWN;
    data_cl     = clear ? 16'h0000 : data_q;
    data_d      = emit ? {data_cl[11:0], code_d} : data_cl;
  end
  assign key_valid = key_valid_q;
  assign key_code  = code_q;
  assign key_down  = down_q;
  assign data      = data_q;
endmodule
